// File: rtl/note_sequencer.sv
// note_sequencer: single-voice note controller for the shared wavetable datapath.
// Owns the phase accumulator and sample divider, tracks held keys with
// last-note priority, and drives the ADSR gate/retrigger.
module note_sequencer #(
    parameter int                   DEPTH       = 1024,
    parameter int                   ACC_WIDTH   = 32,
    parameter int                   SAMPLE_DIV  = 256,
    parameter logic [ACC_WIDTH-1:0] BASE_INC    = 32'd7_158_279,
    parameter logic [ACC_WIDTH-1:0] STEP_INC    = 32'd1_789_570,
    parameter int                   STACK_DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     note_valid_i,
    output logic                     note_ready_o,
    input  logic [3:0]               note_key_i,
    input  logic                     note_on_i,
    input  logic                     env_idle_i,
    output logic [$clog2(DEPTH)-1:0] addr_o,
    output logic                     sample_valid_o,
    output logic                     gate_o,
    output logic                     retrig_o,
    output logic [3:0]               active_key_o,
    output logic                     busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {IDLE, START, PLAY, RELEASE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [DW-1:0]          div;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic [ACC_WIDTH-1:0]   inc;
    logic [3:0]             stack      [STACK_DEPTH];
    logic [3:0]             stack_next [STACK_DEPTH];
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic                   hit;
    logic [IW-1:0]          hit_idx;
    logic [IW-1:0]          pos;
    logic                   accept;

    function automatic logic [ACC_WIDTH-1:0] inc_of(input logic [3:0] key);
        return BASE_INC + ACC_WIDTH'(key) * STEP_INC;
    endfunction

    assign note_ready_o   = (state != START);
    assign retrig_o       = (state == START);
    assign busy_o         = (state != IDLE);
    assign sample_valid_o = (div == DW'(SAMPLE_DIV - 1));
    assign accept         = note_valid_i & note_ready_o;

    // Held-key stack update: entry 0 is the sounding key; entries at or above count are stale.
    always_comb begin
        stack_next = stack;
        count_next = count;
        hit        = 1'b0;
        hit_idx    = '0;
        pos        = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (!hit && i < 32'(count) && stack[i] == note_key_i) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
        if (accept) begin
            if (note_on_i) begin
                // Entries above pos slide down one; a full stack loses its oldest entry.
                if (hit)
                    pos = hit_idx;
                else if (count == CW'(STACK_DEPTH))
                    pos = IW'(STACK_DEPTH - 1);
                else
                    pos = IW'(count);
                for (int unsigned j = 1; j < STACK_DEPTH; j++) begin
                    if (j <= 32'(pos))
                        stack_next[j] = stack[j-1];
                end
                stack_next[0] = note_key_i;
                if (!hit && count != CW'(STACK_DEPTH))
                    count_next = count + 1'b1;
            end else if (hit) begin
                for (int unsigned j = 0; j < STACK_DEPTH - 1; j++) begin
                    if (j >= 32'(hit_idx))
                        stack_next[j] = stack[j+1];
                end
                count_next = count - 1'b1;
            end
        end
    end

    // Next-state logic; a press in RELEASE takes priority over env_idle_i.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept && note_on_i) state_next = START;
            START:   state_next = PLAY;
            PLAY:    if (accept && count_next == '0) state_next = RELEASE;
            RELEASE: begin
                if (accept && note_on_i)
                    state_next = START;
                else if (env_idle_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Phase accumulator: zeroed in START, advanced on strobes while sounding, held in IDLE.
    always_comb begin
        acc_next = acc;
        if (state == START)
            acc_next = '0;
        else if (sample_valid_o && (state == PLAY || state == RELEASE))
            acc_next = acc + inc;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Divider, accumulator, stack, increment, gate and active-key registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div          <= '0;
            acc          <= '0;
            addr_o       <= '0;
            inc          <= '0;
            gate_o       <= 1'b0;
            active_key_o <= '0;
            count        <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++)
                stack[i] <= '0;
        end else begin
            div    <= sample_valid_o ? '0 : div + 1'b1;
            acc    <= acc_next;
            addr_o <= acc_next[ACC_WIDTH-1 -: AW];
            stack  <= stack_next;
            count  <= count_next;
            if (state == START) begin
                gate_o       <= 1'b1;
                inc          <= inc_of(stack[0]);
                active_key_o <= stack[0];
            end else if (state == PLAY && accept) begin
                if (count_next == '0) begin
                    gate_o <= 1'b0;
                end else if (stack_next[0] != stack[0]) begin
                    inc          <= inc_of(stack_next[0]);
                    active_key_o <= stack_next[0];
                end
            end
        end
    end

endmodule
